// File: rtl/nn_layer_scheduler_if.sv
// Control bundle between a layer scheduler and its MAC/activation/output datapath.
interface nn_layer_scheduler_if #(
  parameter int unsigned IDX_W = 8
);
  logic             start_signal;
  logic             ready_signal;
  logic [IDX_W-1:0] in_index;
  logic [IDX_W-1:0] neuron_index;
  logic             mac_clear;
  logic             mac_en;
  logic             bias_en;
  logic             act_en;
  logic             out_wr;
  logic             done_signal;

  modport master (
    input  start_signal,
    output ready_signal, in_index, neuron_index,
    output mac_clear, mac_en, bias_en, act_en, out_wr, done_signal
  );

  modport slave (
    output start_signal,
    input  ready_signal, in_index, neuron_index,
    input  mac_clear, mac_en, bias_en, act_en, out_wr, done_signal
  );
endinterface

// File: rtl/nn_layer_scheduler.sv
// Sequences one fully-connected layer: clear, INPUT_COUNT MACs, activation, write per neuron.
// Optional bias stage between MAC and activation is enabled with `define NN_BIAS_STAGE_EN.
module nn_layer_scheduler #(
  parameter int unsigned INPUT_COUNT  = 8,
  parameter int unsigned NEURON_COUNT = 4,
  parameter int unsigned IDX_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nn_layer_scheduler_if.master  bus
);

  // One extra bit so a full 2^IDX_W count never wraps.
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(INPUT_COUNT - 1);
  localparam logic [CNT_W-1:0] NRN_LAST = CNT_W'(NEURON_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_BIAS, S_ACT, S_WRITE, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] nrn_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      in_cnt  <= '0;
      nrn_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_signal) begin
            state   <= S_CLEAR;
            nrn_cnt <= '0;
            in_cnt  <= '0;
          end
        end
        S_CLEAR: begin
          in_cnt <= '0;
          state  <= S_MAC;
        end
        S_MAC: begin
          if (in_cnt == IN_LAST) begin
`ifdef NN_BIAS_STAGE_EN
            state <= S_BIAS;
`else
            state <= S_ACT;
`endif
          end else begin
            in_cnt <= in_cnt + CNT_W'(1);
          end
        end
        S_BIAS:  state <= S_ACT;
        S_ACT:   state <= S_WRITE;
        S_WRITE: begin
          if (nrn_cnt == NRN_LAST) begin
            state <= S_DONE;
          end else begin
            nrn_cnt <= nrn_cnt + CNT_W'(1);
            state   <= S_CLEAR;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from state and counters; indices read 0 outside their window.
  assign bus.ready_signal = (state == S_IDLE);
  assign bus.mac_clear    = (state == S_CLEAR);
  assign bus.mac_en       = (state == S_MAC);
  assign bus.act_en       = (state == S_ACT);
  assign bus.out_wr       = (state == S_WRITE);
  assign bus.done_signal  = (state == S_DONE);
  assign bus.in_index     = (state == S_MAC) ? in_cnt[IDX_W-1:0] : '0;
  assign bus.neuron_index = (state != S_IDLE && state != S_DONE) ? nrn_cnt[IDX_W-1:0] : '0;

`ifdef NN_BIAS_STAGE_EN
  assign bus.bias_en = (state == S_BIAS);
`else
  assign bus.bias_en = 1'b0;
`endif

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Scoreboard bench for nn_layer_scheduler: stimulus queues per-cycle expected outputs, monitor compares.
module tb_nn_layer_scheduler;

  localparam int IC = 8;
  localparam int IW = 8;
`ifdef NN_BIAS_STAGE_EN
  localparam int NC = 2;
  localparam int P  = IC + 4;
`else
  localparam int NC = 4;
  localparam int P  = IC + 3;
`endif
  localparam int D = NC * P + 1;  // cycle holding done_signal

  typedef struct packed {
    logic          ready;
    logic [IW-1:0] in_index;
    logic [IW-1:0] neuron_index;
    logic          clear;
    logic          mac;
    logic          bias;
    logic          act;
    logic          wr;
    logic          done;
  } vec_t;

  typedef struct {
    int   tid;
    int   k;
    vec_t v;
  } exp_t;

  logic clk;
  logic rst_n;
  nn_layer_scheduler_if #(.IDX_W(IW)) bus ();

  nn_layer_scheduler #(
    .INPUT_COUNT (IC),
    .NEURON_COUNT(NC),
    .IDX_W       (IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t mon_e;
  vec_t mon_a;

  function automatic string tname(input int tid);
    case (tid)
      1: return "reset_idle";
      2: return "single_layer";
      3: return "ignored_start";
      4: return "reset_mid";
      5: return "rerun_after_reset";
      6: return "back_to_back";
      default: return "other";
    endcase
  endfunction

  function automatic vec_t idle_v();
    vec_t v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  // Expected outputs in cycle k after start, derived from the per-neuron period P.
  function automatic vec_t layer_v(input int k);
    vec_t v = '0;
    int   n;
    int   ph;
    if (k >= 1 && k <= NC * P) begin
      n  = (k - 1) / P;
      ph = (k - 1) % P;
      v.neuron_index = IW'(n);
      if (ph == 0) v.clear = 1'b1;
      else if (ph <= IC) begin
        v.mac      = 1'b1;
        v.in_index = IW'(ph - 1);
      end
      else if (ph == P - 1) v.wr = 1'b1;
      else if (ph == P - 2) v.act = 1'b1;
      else v.bias = 1'b1;
    end else if (k == D) begin
      v.done = 1'b1;
    end else begin
      v = idle_v();
    end
    return v;
  endfunction

  task automatic drive(input logic st, input logic rn, input int tid, input int k, input vec_t v);
    exp_t e;
    e.tid = tid;
    e.k   = k;
    e.v   = v;
    sb.push_back(e);
    bus.start_signal = st;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the full output vector each cycle an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = {bus.ready_signal, bus.in_index, bus.neuron_index, bus.mac_clear,
               bus.mac_en, bus.bias_en, bus.act_en, bus.out_wr, bus.done_signal};
      n_tests++;
      if (mon_a !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got rdy/in/nrn/clr/mac/bias/act/wr/done=%b/%0d/%0d/%b%b%b%b%b%b expected %b/%0d/%0d/%b%b%b%b%b%b",
                 tname(mon_e.tid), mon_e.k,
                 mon_a.ready, mon_a.in_index, mon_a.neuron_index, mon_a.clear, mon_a.mac,
                 mon_a.bias, mon_a.act, mon_a.wr, mon_a.done,
                 mon_e.v.ready, mon_e.v.in_index, mon_e.v.neuron_index, mon_e.v.clear,
                 mon_e.v.mac, mon_e.v.bias, mon_e.v.act, mon_e.v.wr, mon_e.v.done);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.start_signal = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle with start low.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1, i, idle_v());

    // Single layer from a one-cycle start pulse.
    drive(1'b1, 1'b1, 2, 0, idle_v());
    for (int k = 1; k <= D + 1; k++) drive(1'b0, 1'b1, 2, k, layer_v(k));

    // Start re-asserted mid-layer and during DONE must be ignored.
    drive(1'b1, 1'b1, 3, 0, idle_v());
    for (int k = 1; k <= D + 2; k++)
      drive((k == 5 || k == D - 15 || k == D), 1'b1, 3, k, layer_v(k));

    // Reset sampled at the edge ending cycle 20 aborts the layer.
    drive(1'b1, 1'b1, 4, 0, idle_v());
    for (int k = 1; k <= 19; k++) drive(1'b0, 1'b1, 4, k, layer_v(k));
    drive(1'b0, 1'b0, 4, 20, layer_v(20));
    drive(1'b0, 1'b1, 4, 21, idle_v());
    drive(1'b0, 1'b1, 4, 22, idle_v());

    // Clean run after the abort.
    drive(1'b1, 1'b1, 5, 0, idle_v());
    for (int k = 1; k <= D + 1; k++) drive(1'b0, 1'b1, 5, k, layer_v(k));

    // Start held high: second layer begins after one ready cycle.
    drive(1'b1, 1'b1, 6, 0, idle_v());
    for (int k = 1; k <= D; k++) drive(1'b1, 1'b1, 6, k, layer_v(k));
    drive(1'b1, 1'b1, 6, D + 1, idle_v());
    for (int k = 1; k <= D; k++) drive((k != D), 1'b1, 6, D + 1 + k, layer_v(k));
    drive(1'b0, 1'b1, 6, 2 * D + 2, idle_v());
    drive(1'b0, 1'b1, 6, 2 * D + 3, idle_v());

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_scheduler.md
Name: nn_layer_scheduler

Overview:
- Sequences one fully-connected layer on the shared MAC/activation datapath.
- For each neuron in turn, it clears the accumulator, streams INPUT_COUNT input/weight indices with MAC enables, fires the activation stage and strobes the result write.
- Sits between the top-level start/ready handshake and the per-layer MAC, activation and output-register datapath.
- One scheduler per layer; layers are chained by feeding done_signal into the next layer's start_signal.

Parameters:
- INPUT_COUNT, 8, inputs (and weights) per neuron; legal range 1..2^IDX_W.
- NEURON_COUNT, 4, neurons in the layer; legal range 1..2^IDX_W.
- IDX_W, 8, width of the index outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start_signal  in  1  layer start request; accepted only in IDLE.
- ready_signal  out  1  high while in IDLE.
- in_index  out  IDX_W  input/weight address; valid while mac_en=1, 0 otherwise.
- neuron_index  out  IDX_W  current neuron; valid in CLEAR..WRITE, 0 in IDLE and DONE.
- mac_clear  out  1  one-cycle accumulator clear.
- mac_en  out  1  accumulate input[in_index]*weight[neuron_index][in_index].
- bias_en  out  1  add bias[neuron_index]; tied 0 unless NN_BIAS_STAGE_EN.
- act_en  out  1  one-cycle activation latch.
- out_wr  out  1  write activation result to output[neuron_index].
- done_signal  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset: synchronous. rst_n=0 at a rising edge forces the following:
  - state=IDLE, both counters=0;
  - ready_signal=1 and every strobe=0 from that edge on;
  - this also applies mid-layer, where the sequence is aborted and no partial done pulse is issued.
- Outputs are combinational decodes of the registered state and counters. There are no output registers.
- State machine. "Cycle k" means the k-th cycle after the edge that sampled start_signal=1 in IDLE.
  - IDLE: ready_signal=1. If start_signal=1, go to CLEAR with neuron counter=0. Otherwise stay.
  - CLEAR: mac_clear=1, in counter=0. Go to MAC.
  - MAC: mac_en=1, in_index=in counter. The counter increments each cycle.
    - When the counter reaches INPUT_COUNT-1, go to BIAS if the macro is defined, else ACT.
    - Exactly INPUT_COUNT MAC cycles per neuron.
  - BIAS (macro only): bias_en=1 for one cycle. Go to ACT.
  - ACT: act_en=1 for one cycle. Go to WRITE.
  - WRITE: out_wr=1.
    - If neuron counter==NEURON_COUNT-1, go to DONE.
    - Otherwise increment the neuron counter and go to CLEAR.
  - DONE: done_signal=1 for one cycle, ready_signal=0. Go to IDLE.
- Latency: per neuron INPUT_COUNT+3 cycles (INPUT_COUNT+4 with bias).
  - done_signal is high in cycle NEURON_COUNT*(INPUT_COUNT+3)+1.
  - ready_signal returns in the next cycle.
- At most one strobe of mac_clear/mac_en/bias_en/act_en/out_wr/done_signal is high in any cycle.
- start_signal outside IDLE (including the DONE cycle) is ignored. It is neither queued nor allowed to restart the sequence.
- start_signal held high continuously:
  - a new layer starts on the IDLE cycle after DONE;
  - this gives back-to-back layers with one ready cycle between them.
- Counters are IDX_W+1 bits internally so that a count of 2^IDX_W does not wrap. Index outputs are the low IDX_W bits.
- INPUT_COUNT=1 gives a single MAC cycle. NEURON_COUNT=1 gives DONE directly after the first WRITE.

Optional Feature:
- Macro: NN_BIAS_STAGE_EN.
- Defined: the BIAS state is inserted between MAC and ACT, with bias_en=1 for one cycle. Per-neuron time becomes INPUT_COUNT+4.
- Undefined: there is no BIAS state, bias_en is constant 0, and timing is as above.

Test Plan:
- Reset then idle (INPUT_COUNT=8, NEURON_COUNT=4): hold rst_n=0 for 2 edges, then release -> ready_signal=1, all strobes 0, both indices 0, with no change while start_signal stays 0.
- Single layer run: pulse start_signal for one cycle -> the following sequence:
  - mac_clear in cycle 1;
  - mac_en in cycles 2-9 with in_index 0..7 and neuron_index 0;
  - act_en in cycle 10 and out_wr in cycle 11;
  - the same pattern for neurons 1-3, with writes in cycles 22, 33 and 44;
  - done_signal in cycle 45 and ready_signal in cycle 46.
- Ignored start: re-assert start_signal in cycles 5, 30 and 45 -> the sequence is identical to the previous scenario with exactly one done pulse.
- Reset mid-operation: rst_n=0 at the edge ending cycle 20 -> ready_signal=1 and strobes 0 in cycle 21, with no done pulse. A new start then runs a full clean sequence.
- Back-to-back: start_signal held at 1 -> done pulses in cycles 45 and 91, with ready_signal high only in cycle 46.
- With NN_BIAS_STAGE_EN and INPUT_COUNT=8, NEURON_COUNT=2 -> bias_en in cycles 10 and 22, out_wr in cycles 12 and 24, done_signal in cycle 25.
